// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - scheduler defaults and shared types for the wakeup matrix
package sched_pkg;

  localparam int SCHED_RS_ENTRIES  = 16;
  localparam int SCHED_NUM_FUS     = 4;
  localparam int SCHED_DISP_WIDTH  = 2;
  localparam int SCHED_ISSUE_WIDTH = 2;
  localparam int SCHED_DEP_W       = SCHED_RS_ENTRIES * SCHED_NUM_FUS;
  localparam int SCHED_IDX_W       = $clog2(SCHED_RS_ENTRIES);

  typedef logic [SCHED_IDX_W-1:0] rs_idx_t;
  typedef logic [SCHED_DEP_W-1:0] dep_vec_t;

endpackage

// File: rtl/wakeup_matrix_if.sv
// rtl/wakeup_matrix_if.sv - dispatch/grant/wakeup bundle between scheduler control and the wakeup matrix
interface wakeup_matrix_if
  import sched_pkg::*;
#(
  parameter int RS_ENTRIES  = SCHED_RS_ENTRIES,
  parameter int NUM_FUS     = SCHED_NUM_FUS,
  parameter int DISP_WIDTH  = SCHED_DISP_WIDTH,
  parameter int ISSUE_WIDTH = SCHED_ISSUE_WIDTH,
  localparam int DEP_W      = RS_ENTRIES * NUM_FUS,
  localparam int IDX_W      = $clog2(RS_ENTRIES)
) ();

  logic [DISP_WIDTH-1:0]             disp_valid;
  logic [DISP_WIDTH-1:0][DEP_W-1:0]  dependency_mask;
  logic [DISP_WIDTH-1:0][IDX_W-1:0]  free_entry_out;
  logic [DISP_WIDTH-1:0]             free_valid_out;
  logic [IDX_W:0]                    count_out;
  logic [RS_ENTRIES-1:0]             reqs;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] grant;
  logic [ISSUE_WIDTH-1:0]            grant_valid;
  logic [DEP_W-1:0]                  ready_mask;
  logic [IDX_W-1:0]                  retire_entry;
  logic                              retire_valid;
  logic                              replay_valid;
  logic [IDX_W-1:0]                  replay_entry;
  logic [DEP_W-1:0]                  replay_mask;
  logic                              flush;

  modport master (
    output disp_valid, dependency_mask, grant, grant_valid, ready_mask,
           retire_entry, retire_valid, replay_valid, replay_entry, replay_mask, flush,
    input  free_entry_out, free_valid_out, count_out, reqs
  );

  modport slave (
    input  disp_valid, dependency_mask, grant, grant_valid, ready_mask,
           retire_entry, retire_valid, replay_valid, replay_entry, replay_mask, flush,
    output free_entry_out, free_valid_out, count_out, reqs
  );

endinterface

// File: rtl/wakeup_free_finder.sv
// rtl/wakeup_free_finder.sv - finds the K lowest-index free entries for parallel dispatch slots
module wakeup_free_finder #(
  parameter int N     = 16,
  parameter int K     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]            free_vec,
  output logic [K-1:0][IDX_W-1:0] idx,
  output logic [K-1:0]            found
);

  // Walk entries low to high; the running free count says which slot a free entry feeds.
  always_comb begin
    logic [IDX_W:0] seen;
    idx   = '0;
    found = '0;
    seen  = '0;
    for (int i = 0; i < N; i++) begin
      if (free_vec[i]) begin
        for (int k = 0; k < K; k++) begin
          if (seen == (IDX_W+1)'(k)) begin
            idx[k]   = IDX_W'(i);
            found[k] = 1'b1;
          end
        end
        seen = seen + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wakeup_matrix.sv
// rtl/wakeup_matrix.sv - dependency-matrix wakeup array; WAKEUP_REPLAY_EN enables the replay re-arm path
module wakeup_matrix
  import sched_pkg::*;
#(
  parameter int RS_ENTRIES  = SCHED_RS_ENTRIES,
  parameter int NUM_FUS     = SCHED_NUM_FUS,
  parameter int DISP_WIDTH  = SCHED_DISP_WIDTH,
  parameter int ISSUE_WIDTH = SCHED_ISSUE_WIDTH,
  localparam int DEP_W      = RS_ENTRIES * NUM_FUS,
  localparam int IDX_W      = $clog2(RS_ENTRIES)
) (
  input logic            clk,
  input logic            rst,
  wakeup_matrix_if.slave bus
);

  logic [RS_ENTRIES-1:0]            valid_q, valid_d;
  logic [RS_ENTRIES-1:0]            granted_q, granted_d;
  logic [RS_ENTRIES-1:0][DEP_W-1:0] dep_q, dep_d;

  logic [RS_ENTRIES-1:0] grant_hit;
  logic [RS_ENTRIES-1:0] replay_hit;
  logic [DISP_WIDTH-1:0] accept;
  logic [IDX_W:0]        occupied;

  // Finder looks at pre-edge state, so a retiring entry is never handed to dispatch the same cycle.
  wakeup_free_finder #(
    .N     (RS_ENTRIES),
    .K     (DISP_WIDTH),
    .IDX_W (IDX_W)
  ) u_free_finder (
    .free_vec (~valid_q),
    .idx      (bus.free_entry_out),
    .found    (bus.free_valid_out)
  );

  assign accept = bus.disp_valid & bus.free_valid_out;

  // Decode all grant ports into a per-entry hit vector; duplicate ports simply OR together.
  always_comb begin
    grant_hit = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
        if (bus.grant_valid[p] && bus.grant[p] == IDX_W'(i)) begin
          grant_hit[i] = 1'b1;
        end
      end
    end
  end

`ifdef WAKEUP_REPLAY_EN
  // Replay only re-arms an entry that is still resident.
  always_comb begin
    replay_hit = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (bus.replay_valid && bus.replay_entry == IDX_W'(i) && valid_q[i]) begin
        replay_hit[i] = 1'b1;
      end
    end
  end
`else
  logic unused_replay;
  assign unused_replay = ^{bus.replay_valid, bus.replay_entry, bus.replay_mask};
  assign replay_hit    = '0;
`endif

  // Request when resident, all producers seen, not yet issued and not being granted right now.
  always_comb begin
    bus.reqs = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      bus.reqs[i] = valid_q[i] && (dep_q[i] == '0) && !granted_q[i] && !grant_hit[i];
    end
  end

  // Next state per entry; later assignments win, giving flush > retire > replay > grant > wakeup.
  always_comb begin
    valid_d   = valid_q;
    granted_d = granted_q | grant_hit;
    dep_d     = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      dep_d[i] = dep_q[i] & ~bus.ready_mask;
      if (replay_hit[i]) begin
        granted_d[i] = 1'b0;
        dep_d[i]     = dep_q[i] | (bus.replay_mask & ~bus.ready_mask);
      end
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (accept[k] && bus.free_entry_out[k] == IDX_W'(i)) begin
          valid_d[i]   = 1'b1;
          granted_d[i] = 1'b0;
          dep_d[i]     = bus.dependency_mask[k] & ~bus.ready_mask;
        end
      end
      if (bus.retire_valid && bus.retire_entry == IDX_W'(i)) begin
        valid_d[i]   = 1'b0;
        granted_d[i] = 1'b0;
        dep_d[i]     = '0;
      end
    end
    if (bus.flush) begin
      valid_d   = '0;
      granted_d = '0;
      dep_d     = '0;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      granted_q <= '0;
      dep_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      granted_q <= granted_d;
      dep_q     <= dep_d;
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      occupied = occupied + {{IDX_W{1'b0}}, valid_q[i]};
    end
  end

  assign bus.count_out = occupied;

endmodule

// File: tb/tb_wakeup_matrix.sv
// tb/tb_wakeup_matrix.sv - directed self-checking bench for wakeup_matrix
module tb_wakeup_matrix;
  import sched_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wakeup_matrix_if bus ();

  wakeup_matrix dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.disp_valid      = '0;
    bus.dependency_mask = '0;
    bus.grant           = '0;
    bus.grant_valid     = '0;
    bus.ready_mask      = '0;
    bus.retire_entry    = '0;
    bus.retire_valid    = 1'b0;
    bus.replay_valid    = 1'b0;
    bus.replay_entry    = '0;
    bus.replay_mask     = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.count_out !== 5'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", bus.count_out);
    end
    checks++;
    if (bus.reqs !== 16'h0000) begin
      errors++; $display("FAIL reset_reqs got %h want 0000", bus.reqs);
    end
    checks++;
    if (bus.free_valid_out !== 2'b11) begin
      errors++; $display("FAIL reset_free_valid got %b want 11", bus.free_valid_out);
    end
    checks++;
    if (bus.free_entry_out[0] !== 4'd0 || bus.free_entry_out[1] !== 4'd1) begin
      errors++; $display("FAIL reset_free_entry got %0d,%0d want 0,1",
                         bus.free_entry_out[0], bus.free_entry_out[1]);
    end
  endtask

  task automatic test_dispatch_basic();
    do_reset();
    bus.disp_valid = 2'b11;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h0003) begin
      errors++; $display("FAIL disp_reqs got %h want 0003", bus.reqs);
    end
    checks++;
    if (bus.count_out !== 5'd2) begin
      errors++; $display("FAIL disp_count got %0d want 2", bus.count_out);
    end
    checks++;
    if (bus.free_entry_out[0] !== 4'd2 || bus.free_entry_out[1] !== 4'd3) begin
      errors++; $display("FAIL disp_free_entry got %0d,%0d want 2,3",
                         bus.free_entry_out[0], bus.free_entry_out[1]);
    end
  endtask

  task automatic test_wakeup();
    dep_vec_t one;
    one = dep_vec_t'(1);
    do_reset();
    bus.disp_valid         = 2'b01;
    bus.dependency_mask[0] = one << 5;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h0000 || bus.count_out !== 5'd1) begin
      errors++; $display("FAIL wake_pending got reqs %h count %0d want 0000 1", bus.reqs, bus.count_out);
    end
    tick();
    bus.ready_mask = one << 5;
    #1;
    checks++;
    if (bus.reqs !== 16'h0000) begin
      errors++; $display("FAIL wake_same_cycle got %h want 0000", bus.reqs);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h0001) begin
      errors++; $display("FAIL wake_next_cycle got %h want 0001", bus.reqs);
    end
    bus.disp_valid         = 2'b11;
    bus.dependency_mask[0] = one << 7;
    bus.dependency_mask[1] = one << 8;
    bus.ready_mask         = one << 7;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h0003) begin
      errors++; $display("FAIL wake_at_dispatch got %h want 0003", bus.reqs);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus.disp_valid = 2'b11;
      tick();
    end
    bus.disp_valid = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (bus.count_out !== 5'd15 || bus.free_valid_out !== 2'b01 || bus.free_entry_out[0] !== 4'd15) begin
      errors++; $display("FAIL full_15 got count %0d fv %b fe %0d want 15 01 15",
                         bus.count_out, bus.free_valid_out, bus.free_entry_out[0]);
    end
    bus.disp_valid = 2'b11;
    tick();
    clear_inputs();
    checks++;
    if (bus.count_out !== 5'd16 || bus.free_valid_out !== 2'b00) begin
      errors++; $display("FAIL full_16 got count %0d fv %b want 16 00", bus.count_out, bus.free_valid_out);
    end
    checks++;
    if (bus.reqs !== 16'hFFFF) begin
      errors++; $display("FAIL full_reqs got %h want ffff", bus.reqs);
    end
    bus.disp_valid = 2'b11;
    tick();
    clear_inputs();
    checks++;
    if (bus.count_out !== 5'd16) begin
      errors++; $display("FAIL full_ignore got %0d want 16", bus.count_out);
    end
  endtask

  task automatic test_grant();
    bus.grant[0]    = 4'd2;
    bus.grant[1]    = 4'd3;
    bus.grant_valid = 2'b11;
    #1;
    checks++;
    if (bus.reqs !== 16'hFFF3) begin
      errors++; $display("FAIL grant_same_cycle got %h want fff3", bus.reqs);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'hFFF3) begin
      errors++; $display("FAIL grant_held got %h want fff3", bus.reqs);
    end
    bus.retire_entry = 4'd2;
    bus.retire_valid = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.free_entry_out[0] !== 4'd2 || bus.free_valid_out !== 2'b01 || bus.count_out !== 5'd15) begin
      errors++; $display("FAIL retire got fe %0d fv %b count %0d want 2 01 15",
                         bus.free_entry_out[0], bus.free_valid_out, bus.count_out);
    end
    bus.grant[0]    = 4'd5;
    bus.grant[1]    = 4'd5;
    bus.grant_valid = 2'b11;
    #1;
    checks++;
    if (bus.reqs !== 16'hFFD3) begin
      errors++; $display("FAIL grant_dup_now got %h want ffd3", bus.reqs);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'hFFD3) begin
      errors++; $display("FAIL grant_dup_held got %h want ffd3", bus.reqs);
    end
  endtask

  task automatic test_replay();
    dep_vec_t one;
    logic [15:0] want_final;
    one = dep_vec_t'(1);
`ifdef WAKEUP_REPLAY_EN
    want_final = 16'h001F;
`else
    want_final = 16'h000F;
`endif
    do_reset();
    bus.disp_valid = 2'b11;
    tick();
    tick();
    bus.disp_valid = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h001F || bus.count_out !== 5'd5) begin
      errors++; $display("FAIL replay_setup got %h count %0d want 001f 5", bus.reqs, bus.count_out);
    end
    bus.grant[0]    = 4'd4;
    bus.grant_valid = 2'b01;
    tick();
    clear_inputs();
    bus.replay_valid = 1'b1;
    bus.replay_entry = 4'd4;
    bus.replay_mask  = one << 9;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== 16'h000F) begin
      errors++; $display("FAIL replay_waiting got %h want 000f", bus.reqs);
    end
    tick();
    checks++;
    if (bus.reqs !== 16'h000F) begin
      errors++; $display("FAIL replay_still_waiting got %h want 000f", bus.reqs);
    end
    bus.ready_mask = one << 9;
    tick();
    clear_inputs();
    checks++;
    if (bus.reqs !== want_final) begin
      errors++; $display("FAIL replay_wakeup got %h want %h", bus.reqs, want_final);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.disp_valid = 2'b11;
      tick();
    end
    clear_inputs();
    checks++;
    if (bus.count_out !== 5'd8 || bus.reqs !== 16'h00FF) begin
      errors++; $display("FAIL flush_setup got count %0d reqs %h want 8 00ff", bus.count_out, bus.reqs);
    end
    bus.flush       = 1'b1;
    bus.disp_valid  = 2'b11;
    bus.grant[0]    = 4'd1;
    bus.grant_valid = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (bus.count_out !== 5'd0 || bus.reqs !== 16'h0000) begin
      errors++; $display("FAIL flush_clear got count %0d reqs %h want 0 0000", bus.count_out, bus.reqs);
    end
    checks++;
    if (bus.free_valid_out !== 2'b11 || bus.free_entry_out[1] !== 4'd1) begin
      errors++; $display("FAIL flush_free got fv %b fe1 %0d want 11 1", bus.free_valid_out, bus.free_entry_out[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_dispatch_basic();
    test_wakeup();
    test_full();
    test_grant();
    test_replay();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wakeup_matrix.md
# wakeup_matrix

Parametrised dependency-matrix wakeup array for one reservation-station scheduler in the backend. Accepts up to DISP_WIDTH dispatches and ISSUE_WIDTH grants per cycle, tracks each entry's outstanding producers as a bit vector over all FU pipes' RS entries, and raises per-entry requests to select. Adds multi-port dispatch, occupancy count, global flush and an optional speculative-wakeup replay path on top of the single-port wakeup block.

## Interface
- RS_ENTRIES, 16, entries in this station (power of two, ≥4)
- NUM_FUS, 4, FU pipes whose RS entries form the dependency space
- DISP_WIDTH, 2, dispatch slots per cycle (1..4)
- ISSUE_WIDTH, 2, grant ports per cycle (1..4)
- DEP_W, RS_ENTRIES*NUM_FUS, derived dependency-vector width; IDX_W = $clog2(RS_ENTRIES)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- disp_valid  in  DISP_WIDTH  per-slot dispatch request
- dependency_mask  in  DISP_WIDTH×DEP_W  per-slot producer vector
- free_entry_out  out  DISP_WIDTH×IDX_W  entry slot k will occupy
- free_valid_out  out  DISP_WIDTH  slot k has a free entry
- count_out  out  IDX_W+1  occupied entries
- reqs  out  RS_ENTRIES  request vector to select
- grant  in  ISSUE_WIDTH×IDX_W  granted entries
- grant_valid  in  ISSUE_WIDTH  grant port valid
- ready_mask  in  DEP_W  producers broadcasting wakeup this cycle
- retire_entry  in  IDX_W  entry to free; retire_valid  in  1
- replay_valid  in  1  re-arm an issued entry (macro-gated)
- replay_entry  in  IDX_W; replay_mask  in  DEP_W  producers to re-wait on
- flush  in  1  discard all entries

## Operation
- Per entry: valid, granted, dep_row[DEP_W]. Every cycle every dep_row clears bits set in ready_mask.
- Free finder: free_entry_out[k] = k-th lowest-index invalid entry (current state); free_valid_out[k]=1 iff ≥k+1 free entries. Slot k accepted iff disp_valid[k] && free_valid_out[k], independent of other slots.
- Accepted slot: entry valid←1, granted←0, dep_row←dependency_mask[k] & ~ready_mask.
- reqs[i] = valid & (dep_row==0) & ~granted & ~(any grant_valid[p] with grant[p]==i) (same-cycle grant suppressed combinationally).
- Grant: granted[grant[p]]←1 per valid port; duplicate ports to one entry legal.
- Retire: valid←0, granted←0, dep_row←0.
- Replay: granted←0, dep_row←dep_row | (replay_mask & ~ready_mask); ignored if entry invalid.
- Flush: all valid/granted/dep_row←0; dispatch, grant, replay that cycle dropped.
- Priority per entry: flush > retire > replay > grant > wakeup clear. Retire and dispatch never collide (finder sees pre-edge state).
- count_out = popcount(valid), registered view of state.

## Timing
- Reset: all entries invalid; reqs=0, count_out=0, free_valid_out=all ones (DISP_WIDTH ≤ RS_ENTRIES), free_entry_out[k]=k.
- Dispatch→reqs: 1 cycle if no surviving dependencies.
- ready_mask→reqs: 1 cycle (registered clear); same-cycle wakeup at dispatch counts.
- Grant→reqs drop: same cycle (combinational), held by granted bit thereafter.
- Replay→reqs: reappears the cycle after replay_mask bits are all cleared; earliest 1 cycle.
- Full: free_valid_out=0 for all slots, disp_valid ignored; partial room accepts low slots only.

## Configuration
- WAKEUP_REPLAY_EN: defined → replay path as above. Undefined → replay_valid/replay_entry/replay_mask ports remain but are ignored; granted only clears on retire/flush.

## Structure
- sched_pkg: RS_ENTRIES, NUM_FUS, DEP_W defaults, typedefs rs_idx_t, dep_vec_t.
- Sub-module wakeup_free_finder: N-way find-first-free over invalid vector, outputs indices and valids.

## Test plan
- Reset then dispatch slots 0,1 with zero masks → entries 0,1 valid, reqs=0x0003 next cycle, count_out=2.
- Dispatch entry 0 dependent on bit 5; ready_mask bit 5 two cycles later → reqs[0] rises the cycle after.
- Fill 15 of 16, dispatch both slots → only slot 0 accepted, free_valid_out=2'b01 before, 2'b00 after.
- Grant entries 2 and 3 on both ports same cycle as reqs → reqs[3:2]=0 that cycle and after; retire 2 → free_entry_out[0]=2.
- WAKEUP_REPLAY_EN: granted entry 4 replayed with mask bit 9 → reqs[4]=0 until ready_mask bit 9, then 1 next cycle; without macro stays 0.
- Flush with 8 valid entries plus concurrent dispatch → count_out=0, reqs=0 next cycle.
